carregador_programa: RTL and testbench



---
 rtl/carregador_programa.sv | 110 +++++++++++
 tb/tb_carregador_programa.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/carregador_programa.sv
// carregador_programa: boot loader that streams header, words and checksum into instruction memory.
// Optional checksum byte and CHECK state enabled by `define CARREGADOR_CHECKSUM_EN.
module carregador_programa #(
    parameter int PROFUNDIDADE = 256,
    parameter int LARG_END     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid,
    output logic                byte_ready,
    input  logic                reiniciar,
    output logic                we_mem,
    output logic [LARG_END-1:0] endereco_mem,
    output logic [31:0]         dado_mem,
    output logic                reset_cpu,
    output logic                carregado,
    output logic                erro
);
    localparam logic [2:0] CAB0      = 3'd0;
    localparam logic [2:0] CAB1      = 3'd1;
    localparam logic [2:0] DADOS     = 3'd2;
    localparam logic [2:0] CONCLUIDO = 3'd4;
    localparam logic [2:0] ERRO      = 3'd5;
`ifdef CARREGADOR_CHECKSUM_EN
    localparam logic [2:0] CHECK     = 3'd3;
    localparam logic [2:0] FIM       = CHECK;
    logic [7:0]  checksum;
`else
    localparam logic [2:0] FIM       = CONCLUIDO;
`endif
    logic [2:0]  estado, prox;
    logic [15:0] contagem, idx, cont_total;
    logic [1:0]  pos;
    logic [23:0] palavra;
    logic        acc, ultimo, terminal;

    assign acc        = byte_valid && byte_ready;
    assign cont_total = {byte_in, contagem[7:0]};
    assign ultimo     = idx + 16'd1 == contagem;
    assign terminal   = estado == CONCLUIDO || estado == ERRO;

    always_comb begin
        prox = estado;
        case (estado)
            CAB0:      if (acc) prox = CAB1;
            CAB1:      if (acc) prox = ({16'd0, cont_total} > PROFUNDIDADE) ? ERRO :
                                       (cont_total == 16'd0) ? FIM : DADOS;
            DADOS:     if (acc && pos == 2'd3 && ultimo) prox = FIM;
`ifdef CARREGADOR_CHECKSUM_EN
            CHECK:     if (acc) prox = (byte_in == checksum) ? CONCLUIDO : ERRO;
`endif
            CONCLUIDO: if (reiniciar) prox = CAB0;
            ERRO:      if (reiniciar) prox = CAB0;
            default:   prox = CAB0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado       <= CAB0;
            byte_ready   <= 1'b0;
            we_mem       <= 1'b0;
            endereco_mem <= '0;
            dado_mem     <= '0;
            reset_cpu    <= 1'b1;
            carregado    <= 1'b0;
            erro         <= 1'b0;
            contagem     <= '0;
            idx          <= '0;
            pos          <= '0;
            palavra      <= '0;
`ifdef CARREGADOR_CHECKSUM_EN
            checksum     <= '0;
`endif
        end else begin
            estado     <= prox;
            byte_ready <= prox != CONCLUIDO && prox != ERRO;
            reset_cpu  <= prox != CONCLUIDO;
            carregado  <= prox == CONCLUIDO;
            erro       <= prox == ERRO;
            we_mem     <= 1'b0;
            if (terminal && reiniciar) begin
                contagem <= '0;
                idx      <= '0;
                pos      <= '0;
`ifdef CARREGADOR_CHECKSUM_EN
                checksum <= '0;
`endif
            end else if (acc) begin
`ifdef CARREGADOR_CHECKSUM_EN
                if (estado != CHECK) checksum <= checksum ^ byte_in;
`endif
                if (estado == CAB0) contagem[7:0] <= byte_in;
                if (estado == CAB1) contagem[15:8] <= byte_in;
                if (estado == DADOS) begin
                    pos     <= pos + 2'd1;
                    palavra <= {byte_in, palavra[23:8]};
                    // little-endian: the fourth byte completes the word as its top byte
                    if (pos == 2'd3) begin
                        we_mem       <= 1'b1;
                        dado_mem     <= {byte_in, palavra};
                        endereco_mem <= idx[LARG_END-1:0];
                        idx          <= idx + 16'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_carregador_programa.sv
// tb_carregador_programa: table-driven and scoreboard bench for the program loader.
module tb_carregador_programa;
    localparam int PROF = 256;
`ifdef CARREGADOR_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif
    logic        clk = 1'b0, reset = 1'b0, byte_valid = 1'b0, reiniciar = 1'b0;
    logic [7:0]  byte_in = 8'd0;
    logic        byte_ready, we_mem, reset_cpu, carregado, erro;
    logic [7:0]  endereco_mem;
    logic [31:0] dado_mem;

    carregador_programa #(.PROFUNDIDADE(PROF), .LARG_END(8)) dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .reiniciar(reiniciar), .we_mem(we_mem),
        .endereco_mem(endereco_mem), .dado_mem(dado_mem), .reset_cpu(reset_cpu),
        .carregado(carregado), .erro(erro)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           id;
        logic [127:0] bytes;
        int           n;
        logic [7:0]   ck;
        bit           com_ck;
        bit           rnd;
        bit           carr;
        bit           err;
        int           nwr;
    } vec_t;

    int          checks = 0, failures = 0, wr_cnt = 0;
    logic [39:0] sb[$];
    logic [7:0]  stream[$];
    logic [31:0] wr_log[PROF];
    vec_t        tab[7];
    localparam logic [127:0] NOM = 128'h0300_B381_2000_3382_2040_6384_4100_0000;

    task automatic chk(input string nome, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nome, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (we_mem) begin
            wr_cnt++;
            wr_log[endereco_mem] = dado_mem;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=%h required=none", {endereco_mem, dado_mem});
            end else chk("write", {endereco_mem, dado_mem}, sb.pop_front());
        end
    end

    task automatic send(input logic [7:0] b, input bit rnd);
        int t;
        if (rnd) while ($urandom_range(0, 1) == 1) begin
            byte_valid = 1'b0;
            @(negedge clk);
        end
        byte_in = b;
        byte_valid = 1'b1;
        t = 0;
        while (!byte_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=byte_ready_low required=byte_ready_high");
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic run_stream(input bit rnd);
        int cnt;
        logic [31:0] w;
        w = 32'd0;
        cnt = (stream.size() >= 2) ? int'({stream[1], stream[0]}) : 0;
        for (int i = 0; i < stream.size(); i++) begin
            if (i >= 2 && cnt <= PROF && i - 2 < 4 * cnt) begin
                w = {stream[i], w[31:8]};
                if ((i - 2) % 4 == 3) sb.push_back({8'((i - 2) / 4), w});
            end
            send(stream[i], rnd);
        end
    endtask

    task automatic load_nominal(input logic [7:0] ck);
        stream.delete();
        for (int i = 0; i < 14; i++) stream.push_back(NOM[127 - 8 * i -: 8]);
        if (CK) stream.push_back(ck);
    endtask

    task automatic chk_reset_vals(input string nome);
        chk({nome, "_byte_ready"}, 40'(byte_ready), 40'(0));
        chk({nome, "_we_mem"}, 40'(we_mem), 40'(0));
        chk({nome, "_endereco"}, 40'(endereco_mem), 40'(0));
        chk({nome, "_dado"}, 40'(dado_mem), 40'(0));
        chk({nome, "_reset_cpu"}, 40'(reset_cpu), 40'(1));
        chk({nome, "_carregado"}, 40'(carregado), 40'(0));
        chk({nome, "_erro"}, 40'(erro), 40'(0));
    endtask

    task automatic do_reset();
        byte_valid = 1'b0;
        reiniciar = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_final(input string nome, input bit carr, input bit err, input int nwr);
        repeat (3) @(negedge clk);
        chk({nome, "_carregado"}, 40'(carregado), 40'(carr));
        chk({nome, "_erro"}, 40'(erro), 40'(err));
        chk({nome, "_reset_cpu"}, 40'(reset_cpu), 40'(!carr));
        chk({nome, "_byte_ready"}, 40'(byte_ready), 40'(0));
        chk({nome, "_nwrites"}, 40'(wr_cnt), 40'(nwr));
        chk({nome, "_sb_empty"}, 40'(sb.size()), 40'(0));
    endtask

    task automatic pulse_reiniciar();
        reiniciar = 1'b1;
        @(negedge clk);
        reiniciar = 1'b0;
        chk("reinic_erro", 40'(erro), 40'(0));
        chk("reinic_carregado", 40'(carregado), 40'(0));
        chk("reinic_reset_cpu", 40'(reset_cpu), 40'(1));
        chk("reinic_byte_ready", 40'(byte_ready), 40'(1));
    endtask

    initial begin
        logic [7:0] x;
        tab[0] = '{0, NOM, 14, 8'h66, 1'b1, 1'b0, 1'b1, 1'b0, 3};
        tab[1] = '{1, NOM, 14, 8'h66, 1'b1, 1'b1, 1'b1, 1'b0, 3};
        tab[2] = '{2, 128'h0000 << 112, 2, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 0};
        tab[3] = '{3, 128'h0101 << 112, 2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tab[4] = '{4, 128'hFFFF << 112, 2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        tab[5] = '{5, 128'h0100_1300_0000 << 80, 6, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 1};
        tab[6] = '{6, 128'h0001 << 112, 2, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0};

        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("por");
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 40'(byte_ready), 40'(1));

        for (int v = 0; v < 6; v++) begin
            do_reset();
            stream.delete();
            for (int i = 0; i < tab[v].n; i++) stream.push_back(tab[v].bytes[127 - 8 * i -: 8]);
            if (CK && tab[v].com_ck) stream.push_back(tab[v].ck);
            wr_cnt = 0;
            run_stream(tab[v].rnd);
            chk_final($sformatf("vec%0d", tab[v].id), tab[v].carr, tab[v].err, tab[v].nwr);
            if (tab[v].id == 1) begin
                chk("rnd_word0", 40'(wr_log[0]), 40'(32'h002081B3));
                chk("rnd_word1", 40'(wr_log[1]), 40'(32'h40208233));
                chk("rnd_word2", 40'(wr_log[2]), 40'(32'h00418463));
            end
        end

        do_reset();
        stream.delete();
        stream.push_back(8'h01);
        stream.push_back(8'h01);
        wr_cnt = 0;
        run_stream(1'b0);
        chk("over_erro_next", 40'(erro), 40'(1));
        chk("over_ready_low", 40'(byte_ready), 40'(0));
        byte_in = 8'hAA;
        byte_valid = 1'b1;
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        chk("over_stall_erro", 40'(erro), 40'(1));
        pulse_reiniciar();
        load_nominal(8'h66);
        for (int i = 0; i < 3; i++) wr_log[i] = 32'd0;
        run_stream(1'b0);
        chk_final("over_reload", 1'b1, 1'b0, 3);
        chk("word0", 40'(wr_log[0]), 40'(32'h002081B3));
        chk("word1", 40'(wr_log[1]), 40'(32'h40208233));
        chk("word2", 40'(wr_log[2]), 40'(32'h00418463));
        reiniciar = 1'b1;
        @(negedge clk);
        reiniciar = 1'b0;
        chk("done_reinic_ready", 40'(byte_ready), 40'(1));

`ifdef CARREGADOR_CHECKSUM_EN
        do_reset();
        load_nominal(8'h67);
        wr_cnt = 0;
        run_stream(1'b0);
        chk_final("badck", 1'b0, 1'b1, 3);
        pulse_reiniciar();
        load_nominal(8'h66);
        wr_cnt = 0;
        run_stream(1'b1);
        chk_final("badck_reload", 1'b1, 1'b0, 3);
`endif

        do_reset();
        load_nominal(8'h66);
        wr_cnt = 0;
        for (int i = 0; i < 5; i++) send(stream[i], 1'b0);
        byte_in = stream[5];
        byte_valid = 1'b1;
        reset = 1'b0;
        #1;
        chk_reset_vals("midreset");
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        chk("midreset_nowrite", 40'(wr_cnt), 40'(0));
        reset = 1'b1;
        @(negedge clk);
        run_stream(1'b0);
        chk_final("midreset_reload", 1'b1, 1'b0, 3);

        do_reset();
        stream.delete();
        stream.push_back(8'h00);
        stream.push_back(8'h01);
        x = 8'h01;
        for (int i = 0; i < 4 * PROF; i++) begin
            stream.push_back(8'(i * 7 + 3));
            x ^= 8'(i * 7 + 3);
        end
        if (CK) stream.push_back(x);
        wr_cnt = 0;
        run_stream(1'b0);
        chk_final("full256", 1'b1, 1'b0, PROF);
        chk("full256_last", 40'(wr_log[PROF - 1]),
            40'({8'(1023 * 7 + 3), 8'(1022 * 7 + 3), 8'(1021 * 7 + 3), 8'(1020 * 7 + 3)}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
